bus_arbiter_n: RTL and testbench

N-master arbiter that sits between the core and its peripheral DRAM clients on one side and the single sdram_controller on the other. It is the parametrised successor to the fixed two-port bus_arbiter. It generalises master count and data/address widths, lets every master both read and write, and offers round-robin or fixed-priority selection. One DRAM transaction is outstanding at a time; request address, data and direction are registered at grant.

---
 rtl/bus_arbiter_n.sv | 178 +++++++++++++++++
 tb/tb_bus_arbiter_n.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_n.sv
// bus_arbiter_n
//   N-master arbiter in front of a single sdram_controller. One DRAM
//   transaction is in flight at a time. The owner's address, write data and
//   direction are captured at grant time. Every output is driven straight
//   from a register, so no input reaches an output combinationally.
//
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   addr, data_in         flattened per-master address / write data
//                         (master i at [i*W +: W])
//   req_read, req_write   per-master level requests (write wins if both)
//   data_out              last completed read word, shared by all masters
//   data_valid            one-cycle read-complete pulse, one bit per master
//   write_complete        one-cycle write-complete pulse, one bit per master
//   grant                 one-hot owner of the current transaction, 0 idle
//   dram_*                controller-side request / completion handshake
module bus_arbiter_n #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 24,
    parameter int DATA_WIDTH  = 32,
    parameter int RR_MODE     = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_MASTERS-1:0]            req_read,
    input  logic [NUM_MASTERS-1:0]            req_write,
    output logic [DATA_WIDTH-1:0]             data_out,
    output logic [NUM_MASTERS-1:0]            data_valid,
    output logic [NUM_MASTERS-1:0]            write_complete,
    output logic [NUM_MASTERS-1:0]            grant,
    output logic [ADDR_WIDTH-1:0]             dram_addr,
    output logic [DATA_WIDTH-1:0]             dram_data_in,
    output logic                              dram_req_read,
    output logic                              dram_req_write,
    input  logic [DATA_WIDTH-1:0]             dram_data_out,
    input  logic                              dram_data_out_valid,
    input  logic                              dram_write_complete
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        rr_last_q, rr_last_d;
    logic [NUM_MASTERS-1:0]  grant_q, grant_d;
    logic [NUM_MASTERS-1:0]  data_valid_q, data_valid_d;
    logic [NUM_MASTERS-1:0]  write_complete_q, write_complete_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic [ADDR_WIDTH-1:0]   dram_addr_q, dram_addr_d;
    logic [DATA_WIDTH-1:0]   dram_data_in_q, dram_data_in_d;
    logic                    rd_q, rd_d;
    logic                    wr_q, wr_d;

    // Unflatten the master buses into packed per-master arrays.
    logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_addr;
    logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_data;
    logic [NUM_MASTERS-1:0]                 req_any;

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_slice
        assign m_addr[g] = addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign m_data[g] = data_in[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign req_any = req_read | req_write;

    // Winner selection. Round-robin scans upward from the master after the
    // last owner, wrapping around. Fixed priority scans upward from master 0.
    logic [IDX_W-1:0] sel, cand;
    logic             found;
    int               idx;

    always_comb begin
        sel   = '0;
        cand  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (RR_MODE != 0) idx = (int'(rr_last_q) + 1 + k) % NUM_MASTERS;
            else              idx = k;
            cand = IDX_W'(idx);
            if (!found && req_any[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        rr_last_d        = rr_last_q;
        grant_d          = grant_q;
        data_out_d       = data_out_q;
        dram_addr_d      = dram_addr_q;
        dram_data_in_d   = dram_data_in_q;
        rd_d             = rd_q;
        wr_d             = wr_q;
        // Completion pulses live for the single HOLD cycle only.
        data_valid_d     = '0;
        write_complete_d = '0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d        = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << sel;
                    dram_addr_d    = m_addr[sel];
                    dram_data_in_d = m_data[sel];
                    wr_d           = req_write[sel];
                    rd_d           = !req_write[sel];
                    rr_last_d      = sel;
                    state_d        = BUSY;
                end
            end
            BUSY: begin
                // A completion for the other direction is not ours to act on.
                if ((wr_q && dram_write_complete) || (rd_q && dram_data_out_valid)) begin
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                    if (rd_q) begin
                        data_out_d   = dram_data_out;
                        data_valid_d = grant_q;
                    end else begin
                        write_complete_d = grant_q;
                    end
                    state_d = HOLD;
                end
            end
            HOLD: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            rr_last_q        <= IDX_W'(NUM_MASTERS - 1);
            grant_q          <= '0;
            data_valid_q     <= '0;
            write_complete_q <= '0;
            data_out_q       <= '0;
            dram_addr_q      <= '0;
            dram_data_in_q   <= '0;
            rd_q             <= 1'b0;
            wr_q             <= 1'b0;
        end else begin
            state_q          <= state_d;
            rr_last_q        <= rr_last_d;
            grant_q          <= grant_d;
            data_valid_q     <= data_valid_d;
            write_complete_q <= write_complete_d;
            data_out_q       <= data_out_d;
            dram_addr_q      <= dram_addr_d;
            dram_data_in_q   <= dram_data_in_d;
            rd_q             <= rd_d;
            wr_q             <= wr_d;
        end
    end

    assign data_out       = data_out_q;
    assign data_valid     = data_valid_q;
    assign write_complete = write_complete_q;
    assign grant          = grant_q;
    assign dram_addr      = dram_addr_q;
    assign dram_data_in   = dram_data_in_q;
    assign dram_req_read  = rd_q;
    assign dram_req_write = wr_q;

endmodule

// File: tb/tb_bus_arbiter_n.sv
// tb_bus_arbiter_n
//   Drives one fixed-priority (index 0) and one round-robin (index 1)
//   arbiter with identical master and controller stimulus. A transaction-level
//   model predicts each instance's outputs every cycle. Directed literal
//   checks pin the model to hand-computed values.
module tb_bus_arbiter_n;

    localparam int N  = 4;
    localparam int AW = 24;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N*AW-1:0]   addr;
    logic [N*DW-1:0]   data_in;
    logic [N-1:0]      req_read, req_write;
    logic [DW-1:0]     dram_data_out;
    logic              dram_data_out_valid, dram_write_complete;

    logic [DW-1:0]     data_out_w[2];
    logic [N-1:0]      data_valid_w[2], write_complete_w[2], grant_w[2];
    logic [AW-1:0]     dram_addr_w[2];
    logic [DW-1:0]     dram_data_in_w[2];
    logic              dram_req_read_w[2], dram_req_write_w[2];

    always #5 clk = ~clk;

    bus_arbiter_n #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(0)) u_fp (
        .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in),
        .req_read(req_read), .req_write(req_write),
        .data_out(data_out_w[0]), .data_valid(data_valid_w[0]),
        .write_complete(write_complete_w[0]), .grant(grant_w[0]),
        .dram_addr(dram_addr_w[0]), .dram_data_in(dram_data_in_w[0]),
        .dram_req_read(dram_req_read_w[0]), .dram_req_write(dram_req_write_w[0]),
        .dram_data_out(dram_data_out), .dram_data_out_valid(dram_data_out_valid),
        .dram_write_complete(dram_write_complete)
    );

    bus_arbiter_n #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in),
        .req_read(req_read), .req_write(req_write),
        .data_out(data_out_w[1]), .data_valid(data_valid_w[1]),
        .write_complete(write_complete_w[1]), .grant(grant_w[1]),
        .dram_addr(dram_addr_w[1]), .dram_data_in(dram_data_in_w[1]),
        .dram_req_read(dram_req_read_w[1]), .dram_req_write(dram_req_write_w[1]),
        .dram_data_out(dram_data_out), .dram_data_out_valid(dram_data_out_valid),
        .dram_write_complete(dram_write_complete)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // owner < 0 means no transaction; hold marks the reporting cycle.
    int          m_owner[2];
    bit          m_wr[2], m_hold[2];
    logic [DW-1:0] m_dout[2], m_wdata[2];
    logic [AW-1:0] m_addr[2];
    int          m_rr[2];
    int          pick_c[2];

    function automatic int pick_master(input bit rr, input int last, input logic [N-1:0] req);
        int c;
        pick_master = -1;
        for (int k = 0; k < N; k++) begin
            c = rr ? (last + 1 + k) % N : k;
            if (pick_master < 0 && ((req >> c) & 4'd1) != 4'd0) pick_master = c;
        end
    endfunction

    always_comb begin
        for (int i = 0; i < 2; i++) pick_c[i] = pick_master(i == 1, m_rr[i], req_read | req_write);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_owner[i] <= -1; m_wr[i] <= 1'b0; m_hold[i] <= 1'b0;
                m_dout[i] <= '0; m_wdata[i] <= '0; m_addr[i] <= '0; m_rr[i] <= N - 1;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_owner[i] < 0) begin
                    if (pick_c[i] >= 0) begin
                        m_owner[i] <= pick_c[i];
                        m_wr[i]    <= req_write[pick_c[i]];
                        m_addr[i]  <= addr[pick_c[i]*AW +: AW];
                        m_wdata[i] <= data_in[pick_c[i]*DW +: DW];
                        m_rr[i]    <= pick_c[i];
                        m_hold[i]  <= 1'b0;
                    end
                end else if (!m_hold[i]) begin
                    if (m_wr[i] ? dram_write_complete : dram_data_out_valid) begin
                        m_hold[i] <= 1'b1;
                        if (!m_wr[i]) m_dout[i] <= dram_data_out;
                    end
                end else begin
                    m_owner[i] <= -1;
                    m_hold[i]  <= 1'b0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [N-1:0] exp_g;
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            exp_g = (m_owner[i] >= 0) ? N'(1 << m_owner[i]) : '0;
            chk($sformatf("model grant inst%0d", i), grant_w[i], exp_g);
            chk($sformatf("model rd inst%0d", i), dram_req_read_w[i],
                m_owner[i] >= 0 && !m_hold[i] && !m_wr[i]);
            chk($sformatf("model wr inst%0d", i), dram_req_write_w[i],
                m_owner[i] >= 0 && !m_hold[i] && m_wr[i]);
            chk($sformatf("model data_valid inst%0d", i), data_valid_w[i],
                (m_hold[i] && !m_wr[i]) ? exp_g : '0);
            chk($sformatf("model write_complete inst%0d", i), write_complete_w[i],
                (m_hold[i] && m_wr[i]) ? exp_g : '0);
            chk($sformatf("model data_out inst%0d", i), data_out_w[i], m_dout[i]);
            if (m_owner[i] >= 0 && !m_hold[i]) begin
                chk($sformatf("model dram_addr inst%0d", i), dram_addr_w[i], m_addr[i]);
                chk($sformatf("model dram_data_in inst%0d", i), dram_data_in_w[i], m_wdata[i]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [N-1:0] exp_rr_order[6];

    initial begin
        exp_rr_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        rst_n = 1'b0;
        addr = '0; data_in = '0; req_read = '0; req_write = '0;
        dram_data_out = '0; dram_data_out_valid = 1'b0; dram_write_complete = 1'b0;
        cyc(3);
        chk("reset grant", grant_w[1], 4'b0000);
        chk("reset data_out", data_out_w[1], 32'h0);
        chk("reset dram_req_read", dram_req_read_w[1], 1'b0);
        rst_n = 1'b1;
        cyc(1);

        // Master 2 read, controller answers after 5 cycles.
        addr[2*AW +: AW] = 24'h001234;
        req_read[2] = 1'b1;
        cyc(1);
        chk("m2 read dram_req_read", dram_req_read_w[1], 1'b1);
        chk("m2 read dram_addr", dram_addr_w[1], 24'h001234);
        chk("m2 read grant", grant_w[1], 4'b0100);
        cyc(4);
        dram_data_out = 32'hDEADBEEF; dram_data_out_valid = 1'b1;
        cyc(1);
        dram_data_out_valid = 1'b0; req_read[2] = 1'b0;
        chk("m2 read data_valid", data_valid_w[1], 4'b0100);
        chk("m2 read data_out", data_out_w[1], 32'hDEADBEEF);
        chk("m2 read dram_req_read cleared", dram_req_read_w[1], 1'b0);
        cyc(1);
        chk("m2 read pulse one cycle", data_valid_w[1], 4'b0000);
        chk("m2 read grant after hold", grant_w[1], 4'b0000);

        // Master 1 write.
        addr[1*AW +: AW] = 24'h000010; data_in[1*DW +: DW] = 32'hCAFEF00D;
        req_write[1] = 1'b1;
        cyc(1);
        chk("m1 write dram_req_write", dram_req_write_w[1], 1'b1);
        chk("m1 write dram_data_in", dram_data_in_w[1], 32'hCAFEF00D);
        cyc(2);
        dram_write_complete = 1'b1;
        cyc(1);
        dram_write_complete = 1'b0; req_write[1] = 1'b0;
        chk("m1 write_complete", write_complete_w[1], 4'b0010);
        chk("m1 write data_valid", data_valid_w[1], 4'b0000);
        cyc(1);

        // Master 0 write with a stray read-complete in the middle.
        addr[0*AW +: AW] = 24'h000020; data_in[0*DW +: DW] = 32'hA5A50000;
        req_write[0] = 1'b1;
        cyc(2);
        dram_data_out = 32'h11111111; dram_data_out_valid = 1'b1;
        cyc(1);
        dram_data_out_valid = 1'b0;
        chk("stray pulse dram_req_write held", dram_req_write_w[1], 1'b1);
        chk("stray pulse data_valid", data_valid_w[1], 4'b0000);
        cyc(1);
        dram_write_complete = 1'b1;
        cyc(1);
        dram_write_complete = 1'b0; req_write[0] = 1'b0;
        chk("m0 write_complete", write_complete_w[1], 4'b0001);
        chk("stray pulse data_out kept", data_out_w[1], 32'hDEADBEEF);
        cyc(1);

        // Master 3 read+write together: write wins.
        addr[3*AW +: AW] = 24'h000030; data_in[3*DW +: DW] = 32'h33330003;
        req_read[3] = 1'b1; req_write[3] = 1'b1;
        cyc(1);
        chk("m3 both dram_req_write", dram_req_write_w[1], 1'b1);
        chk("m3 both dram_req_read", dram_req_read_w[1], 1'b0);
        cyc(1);
        dram_write_complete = 1'b1;
        cyc(1);
        dram_write_complete = 1'b0; req_read[3] = 1'b0; req_write[3] = 1'b0;
        chk("m3 both write_complete", write_complete_w[1], 4'b1000);
        chk("m3 both data_valid", data_valid_w[1], 4'b0000);
        cyc(1);

        // All masters request continuously.
        req_read = 4'b1111;
        for (int t = 0; t < 6; t++) begin
            cyc(1);
            chk($sformatf("rr order %0d", t), grant_w[1], exp_rr_order[t]);
            chk($sformatf("fp order %0d", t), grant_w[0], 4'b0001);
            dram_data_out = 32'h100 + t; dram_data_out_valid = 1'b1;
            cyc(1);
            dram_data_out_valid = 1'b0;
            if (t == 5) req_read = '0;
            cyc(1);
        end

        // Reset two cycles into BUSY.
        req_read[0] = 1'b1;
        cyc(2);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("async reset grant inst%0d", i), grant_w[i], 4'b0000);
            chk($sformatf("async reset rd inst%0d", i), dram_req_read_w[i], 1'b0);
            chk($sformatf("async reset data_valid inst%0d", i), data_valid_w[i], 4'b0000);
        end
        req_read[0] = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        dram_data_out = 32'h55555555; dram_data_out_valid = 1'b1;
        cyc(1);
        dram_data_out_valid = 1'b0;
        cyc(1);
        chk("idle completion ignored", data_valid_w[1], 4'b0000);
        chk("idle completion data_out", data_out_w[1], 32'h0);
        req_read[0] = 1'b1; req_read[3] = 1'b1;
        cyc(1);
        chk("post-reset rr grant", grant_w[1], 4'b0001);
        chk("post-reset fp grant", grant_w[0], 4'b0001);
        dram_data_out = 32'h77; dram_data_out_valid = 1'b1;
        cyc(1);
        dram_data_out_valid = 1'b0; req_read = '0;
        chk("post-reset data_valid", data_valid_w[1], 4'b0001);
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
